// File: rtl/uart_pkg.sv
// Shared constants and types for the parametrised UART receive path and its
// companion transmitter.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PAR       = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } rx_state_t;

    // A FIFO entry carries {perr, ferr, data}.
    function automatic int entry_width(input int data_bits);
        return data_bits + 2;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Synchronous FIFO with the head entry held in a register, so rdata changes
// only when an entry is pushed into an empty FIFO or the head is popped.
module sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rdata  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (do_push && (empty || (do_pop && count == (AW+1)'(1)))) begin
                rdata <= wdata;
            end else if (do_pop && count > (AW+1)'(1)) begin
                rdata <= mem[rd_ptr + 1'b1];
            end
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with configurable framing, start-glitch rejection and
// per-frame error flags, feeding a small valid/ready FIFO.
//
// state      | meaning
// IDLE       | line idle, waiting for a low level
// START      | start bit seen, confirming it at mid-bit
// DATA       | sampling data bits mid-bit, LSB first
// PAR        | sampling the parity bit
// STOP       | sampling stop bit(s); pushes the frame on the last one
// WAIT_HIGH  | line held low after a frame; waiting for it to go idle
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_PER_HALF_BIT = 520,
    parameter int DATA_BITS        = 8,
    parameter int PARITY           = 0,
    parameter int STOP_BITS        = 1,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rdata,
    output logic                 rvalid,
    input  logic                 rready,
    output logic                 perr,
    output logic                 ferr,
    output logic                 overrun,
    input  logic                 clr_overrun
);

    localparam int ENTRY_W = entry_width(DATA_BITS);
    localparam int CNT_W   = $clog2(2 * CLK_PER_HALF_BIT);
    localparam logic [CNT_W-1:0] HALF_TC   = CNT_W'(CLK_PER_HALF_BIT - 1);
    localparam logic [CNT_W-1:0] FULL_TC   = CNT_W'(2 * CLK_PER_HALF_BIT - 1);
    localparam logic [3:0]       LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);

    rx_state_t            state;
    rx_state_t            next_state;
    logic                 rx_meta;
    logic                 rx_s;
    logic [CNT_W-1:0]     baud_cnt;
    logic [3:0]           bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 perr_q;
    logic                 ferr_q;
    logic                 half_tick;
    logic                 full_tick;
    logic                 par_calc;
    logic                 par_bad;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [ENTRY_W-1:0]   fifo_wdata;
    logic [ENTRY_W-1:0]   fifo_rdata;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rx_s    <= rx_meta;
        end
    end

    assign half_tick = (baud_cnt == HALF_TC);
    assign full_tick = (baud_cnt == FULL_TC);
    assign par_calc  = (^shreg) ^ rx_s;
    assign par_bad   = (PARITY == PAR_ODD) ? ~par_calc : par_calc;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE: begin
                if (!rx_s) next_state = ST_START;
            end
            ST_START: begin
                if (rx_s) begin
                    next_state = ST_IDLE;
                end else if (half_tick) begin
                    next_state = ST_DATA;
                end
            end
            ST_DATA: begin
                if (full_tick && bit_idx == LAST_DATA) begin
                    next_state = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
                end
            end
            ST_PAR: begin
                if (full_tick) next_state = ST_STOP;
            end
            ST_STOP: begin
                if (full_tick && bit_idx == LAST_STOP) begin
                    next_state = rx_s ? ST_IDLE : ST_WAIT_HIGH;
                end
            end
            ST_WAIT_HIGH: begin
                if (rx_s) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        fifo_push = 1'b0;
        if (state == ST_STOP && full_tick && bit_idx == LAST_STOP) begin
            fifo_push = 1'b1;
        end
    end

    // The final stop sample is folded into ferr combinationally so the push needs no extra cycle.
    assign fifo_wdata = {perr_q, ferr_q | ~rx_s, shreg};

    // bit_idx counts data bits in DATA and stop bits in STOP; both restart on state entry.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            if (state != next_state) begin
                baud_cnt <= '0;
                bit_idx  <= '0;
            end else begin
                baud_cnt <= full_tick ? '0 : baud_cnt + 1'b1;
                if (full_tick && (state == ST_DATA || state == ST_STOP)) begin
                    bit_idx <= bit_idx + 1'b1;
                end
            end
            if (state == ST_START) begin
                perr_q <= 1'b0;
                ferr_q <= 1'b0;
            end
            if (state == ST_DATA && full_tick) begin
                shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            end
            if (state == ST_PAR && full_tick) begin
                perr_q <= par_bad;
            end
            if (state == ST_STOP && full_tick && !rx_s) begin
                ferr_q <= 1'b1;
            end
        end
    end

    assign fifo_pop = rvalid && rready;

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign rvalid              = !fifo_empty;
    assign {perr, ferr, rdata} = fifo_rdata;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            overrun <= 1'b0;
        end else if (fifo_push && fifo_full && !fifo_pop) begin
            overrun <= 1'b1;
        end else if (clr_overrun) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: three framing configurations share one
// clock; a per-instance queue holds the expected {perr, ferr, data} entries.
module tb_uart_rx_fifo;

    localparam int H     = 4;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rstn;
    logic rxd_a, rxd_p, rxd_s;
    logic rready_a, rready_p, rready_s;
    logic clr_a, clr_p, clr_s;
    logic [7:0] rdata_a, rdata_s;
    logic [6:0] rdata_p;
    logic rvalid_a, rvalid_p, rvalid_s;
    logic perr_a, perr_p, perr_s;
    logic ferr_a, ferr_p, ferr_s;
    logic ovr_a, ovr_p, ovr_s;

    int sel;
    logic       obs_valid, obs_perr, obs_ferr, obs_ovr;
    logic [8:0] obs_data;

    int vecs = 0;
    int miscmp = 0;
    logic [10:0] q_a[$];
    logic [10:0] q_p[$];
    logic [10:0] q_s[$];
    logic ov_exp;

    always #5 clk = ~clk;

    uart_rx_fifo #(.CLK_PER_HALF_BIT(H), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_a (
        .clk(clk), .rstn(rstn), .rxd(rxd_a), .rdata(rdata_a), .rvalid(rvalid_a), .rready(rready_a),
        .perr(perr_a), .ferr(ferr_a), .overrun(ovr_a), .clr_overrun(clr_a));

    uart_rx_fifo #(.CLK_PER_HALF_BIT(H), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_p (
        .clk(clk), .rstn(rstn), .rxd(rxd_p), .rdata(rdata_p), .rvalid(rvalid_p), .rready(rready_p),
        .perr(perr_p), .ferr(ferr_p), .overrun(ovr_p), .clr_overrun(clr_p));

    uart_rx_fifo #(.CLK_PER_HALF_BIT(H), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) u_s (
        .clk(clk), .rstn(rstn), .rxd(rxd_s), .rdata(rdata_s), .rvalid(rvalid_s), .rready(rready_s),
        .perr(perr_s), .ferr(ferr_s), .overrun(ovr_s), .clr_overrun(clr_s));

    always_comb begin
        obs_valid = 1'b0; obs_data = '0; obs_perr = 1'b0; obs_ferr = 1'b0; obs_ovr = 1'b0;
        case (sel)
            0: begin obs_valid = rvalid_a; obs_data = {1'b0, rdata_a}; obs_perr = perr_a; obs_ferr = ferr_a; obs_ovr = ovr_a; end
            1: begin obs_valid = rvalid_p; obs_data = {2'b0, rdata_p}; obs_perr = perr_p; obs_ferr = ferr_p; obs_ovr = ovr_p; end
            2: begin obs_valid = rvalid_s; obs_data = {1'b0, rdata_s}; obs_perr = perr_s; obs_ferr = ferr_s; obs_ovr = ovr_s; end
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miscmp++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_rxd(input int which, input logic v);
        case (which)
            0: rxd_a = v;
            1: rxd_p = v;
            default: rxd_s = v;
        endcase
    endtask

    task automatic set_rready(input int which, input logic v);
        case (which)
            0: rready_a = v;
            1: rready_p = v;
            default: rready_s = v;
        endcase
    endtask

    task automatic sb_push(input int which, input logic [10:0] e);
        case (which)
            0: q_a.push_back(e);
            1: q_p.push_back(e);
            default: q_s.push_back(e);
        endcase
    endtask

    function automatic int sb_size(input int which);
        case (which)
            0: return q_a.size();
            1: return q_p.size();
            default: return q_s.size();
        endcase
    endfunction

    task automatic sb_pop(input int which, output logic [10:0] e, output bit ok);
        ok = (sb_size(which) != 0);
        e = '0;
        if (ok) begin
            case (which)
                0: e = q_a.pop_front();
                1: e = q_p.pop_front();
                default: e = q_s.pop_front();
            endcase
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Compares the observed head against an expected entry.
    task automatic cmp_head(input string tag, input logic [10:0] e);
        chk({tag, " rvalid"}, 32'(obs_valid), 32'd1);
        chk({tag, " rdata"}, 32'(obs_data), 32'(e[8:0]));
        chk({tag, " perr"}, 32'(obs_perr), 32'(e[10]));
        chk({tag, " ferr"}, 32'(obs_ferr), 32'(e[9]));
    endtask

    task automatic check_head(input int which, input string tag);
        logic [10:0] e;
        bit ok;
        sel = which;
        @(negedge clk);
        sb_pop(which, e, ok);
        vecs++;
        assert (ok) else begin
            miscmp++;
            $error("FAIL %s: observed empty scoreboard expected an entry", tag);
        end
        if (ok) cmp_head(tag, e);
        set_rready(which, 1'b1);
        @(negedge clk);
        set_rready(which, 1'b0);
    endtask

    // Drives one frame bit-by-bit. pop_cycle raises rready for that single
    // cycle; abort_cycle asserts rstn there and returns without a push.
    task automatic send_frame(input int which, input logic [8:0] data, input int nbits,
                              input int par_mode, input bit par_flip, input int nstop,
                              input logic [1:0] stop_pat, input int pop_cycle,
                              input int abort_cycle, output int first_valid);
        logic bits[$];
        logic [8:0] mask;
        logic par;
        logic ferr_e;
        logic perr_e;
        logic [10:0] e;
        bit ok;
        int total;
        sel = which;
        mask = '0;
        for (int i = 0; i < nbits; i++) mask[i] = 1'b1;
        bits.push_back(1'b0);
        for (int i = 0; i < nbits; i++) bits.push_back(data[i]);
        perr_e = 1'b0;
        if (par_mode != 0) begin
            par = ^(data & mask);
            if (par_mode == 1) par = ~par;
            par = par ^ par_flip;
            perr_e = par_flip;
            bits.push_back(par);
        end
        ferr_e = 1'b0;
        for (int i = 0; i < nstop; i++) begin
            bits.push_back(stop_pat[i]);
            if (!stop_pat[i]) ferr_e = 1'b1;
        end
        total = bits.size() * 2 * H;
        first_valid = -1;
        for (int c = 0; c < total; c++) begin
            @(negedge clk);
            if (c == abort_cycle) begin
                rstn = 1'b0;
                set_rxd(which, 1'b1);
                return;
            end
            if (first_valid < 0 && c > 0 && obs_valid) first_valid = c;
            set_rxd(which, bits[c / (2 * H)]);
            set_rready(which, c == pop_cycle);
            if (c == pop_cycle) begin
                sb_pop(which, e, ok);
                if (ok) cmp_head("same-cycle pop", e);
            end
        end
        @(negedge clk);
        set_rready(which, 1'b0);
        if (sb_size(which) < DEPTH) sb_push(which, {perr_e, ferr_e, data & mask});
        else ov_exp = 1'b1;
    endtask

    task automatic chk_latency(input string tag, input int got, input int lat);
        vecs++;
        assert (got >= lat - 2 && got <= lat + 2) else begin
            miscmp++;
            $error("FAIL %s: observed %0d cycles expected %0d +/-2", tag, got, lat);
        end
    endtask

    initial begin
        int fv;
        rstn = 1'b0;
        rxd_a = 1'b1; rxd_p = 1'b1; rxd_s = 1'b1;
        rready_a = 1'b0; rready_p = 1'b0; rready_s = 1'b0;
        clr_a = 1'b0; clr_p = 1'b0; clr_s = 1'b0;
        sel = 0;
        ov_exp = 1'b0;
        idle(4);
        chk("reset rvalid", 32'(obs_valid), 32'd0);
        chk("reset rdata", 32'(obs_data), 32'd0);
        chk("reset perr", 32'(obs_perr), 32'd0);
        chk("reset ferr", 32'(obs_ferr), 32'd0);
        chk("reset overrun", 32'(obs_ovr), 32'd0);
        rstn = 1'b1;
        idle(10);

        // 8N1 single frame
        send_frame(0, 9'h0A5, 8, 0, 1'b0, 1, 2'b11, -1, -1, fv);
        chk_latency("8N1 latency", fv, 2 + H + 2 * H * 9 + 1);
        check_head(0, "8N1 A5");
        idle(2);
        chk("8N1 drained", 32'(obs_valid), 32'd0);

        // 7E1: correct then bad parity
        send_frame(1, 9'h035, 7, 2, 1'b0, 1, 2'b11, -1, -1, fv);
        chk_latency("7E1 latency", fv, 2 + H + 2 * H * 9 + 1);
        check_head(1, "7E1 good");
        idle(4);
        send_frame(1, 9'h035, 7, 2, 1'b1, 1, 2'b11, -1, -1, fv);
        check_head(1, "7E1 bad parity");

        // 8N2 with second stop low, line then held low
        send_frame(2, 9'h03C, 8, 0, 1'b0, 2, 2'b01, -1, -1, fv);
        chk_latency("8N2 latency", fv, 2 + H + 2 * H * 10 + 1);
        check_head(2, "8N2 ferr");
        idle(40);
        chk("held low no push", 32'(obs_valid), 32'd0);
        rxd_s = 1'b1;
        idle(2 * H);
        send_frame(2, 9'h011, 8, 0, 1'b0, 2, 2'b11, -1, -1, fv);
        check_head(2, "8N2 after break");

        // start glitch
        sel = 0;
        @(negedge clk); rxd_a = 1'b0;
        idle(2); rxd_a = 1'b1;
        idle(100);
        chk("glitch rvalid", 32'(obs_valid), 32'd0);

        // overrun: five frames, nobody reading
        for (int i = 1; i <= 5; i++) begin
            send_frame(0, 9'(i), 8, 0, 1'b0, 1, 2'b11, -1, -1, fv);
            idle(3);
        end
        chk("overrun set", 32'(obs_ovr), 32'(ov_exp));
        for (int i = 0; i < DEPTH; i++) check_head(0, "drain full");
        idle(1);
        chk("drained empty", 32'(obs_valid), 32'd0);
        chk("overrun held", 32'(obs_ovr), 32'd1);
        clr_a = 1'b1;
        @(negedge clk); clr_a = 1'b0;
        idle(1);
        chk("overrun cleared", 32'(obs_ovr), 32'd0);

        // full FIFO, pop exactly in the fifth frame's push cycle
        ov_exp = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            send_frame(0, 9'(i), 8, 0, 1'b0, 1, 2'b11, -1, -1, fv);
            idle(3);
        end
        send_frame(0, 9'h005, 8, 0, 1'b0, 1, 2'b11, 1 + H + 2 * H * 9, -1, fv);
        idle(2);
        chk("pop-push overrun", 32'(obs_ovr), 32'(ov_exp));
        for (int i = 0; i < DEPTH; i++) check_head(0, "drain pop-push");

        // reset mid-frame with a held entry
        send_frame(0, 9'h05A, 8, 0, 1'b0, 1, 2'b11, -1, -1, fv);
        idle(3);
        chk("pre-reset rvalid", 32'(obs_valid), 32'd1);
        send_frame(0, 9'h077, 8, 0, 1'b0, 1, 2'b11, -1, 40, fv);
        @(negedge clk);
        chk("midreset rvalid", 32'(obs_valid), 32'd0);
        chk("midreset rdata", 32'(obs_data), 32'd0);
        chk("midreset perr", 32'(obs_perr), 32'd0);
        chk("midreset ferr", 32'(obs_ferr), 32'd0);
        chk("midreset overrun", 32'(obs_ovr), 32'd0);
        rstn = 1'b1;
        q_a.delete();
        idle(120);
        chk("no partial push", 32'(obs_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
        $finish;
    end

endmodule
